// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the MIPS multi-cycle control FSM and the ALU control decoder.
package mips_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [3:0] ALUOP_ADD    = 4'b0000;
    localparam logic [3:0] ALUOP_SUB    = 4'b0001;
    localparam logic [3:0] ALUOP_RTYPE  = 4'b0010;
    localparam logic [3:0] ALUOP_ADDU   = 4'b0011;
    localparam logic [3:0] ALUOP_AND    = 4'b0100;
    localparam logic [3:0] ALUOP_OR     = 4'b0101;
    localparam logic [3:0] ALUOP_XOR    = 4'b0110;
    localparam logic [3:0] ALUOP_SLTU   = 4'b0111;
    localparam logic [3:0] ALUOP_BNE    = 4'b1000;
    localparam logic [3:0] ALUOP_BGTZ   = 4'b1001;
    localparam logic [3:0] ALUOP_BLEZ   = 4'b1010;
    localparam logic [3:0] ALUOP_REGIMM = 4'b1011;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       is_link;
        logic       legal;
    } dec_t;
endpackage

// File: rtl/mips_opcode_decode.sv
// mips_opcode_decode: combinational opcode classification and ALU operation class.
module mips_opcode_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    output dec_t       dec_o
);
    always_comb begin
        dec_o       = '0;
        dec_o.legal = 1'b1;
        case (opcode_i)
            OP_RTYPE:  dec_o.alu_op = ALUOP_RTYPE;
            OP_LW:     dec_o.is_load = 1'b1;
            OP_SW:     dec_o.is_store = 1'b1;
            OP_ADDIU:  dec_o.alu_op = ALUOP_ADDU;
            OP_ANDI:   dec_o.alu_op = ALUOP_AND;
            OP_ORI:    dec_o.alu_op = ALUOP_OR;
            OP_XORI:   dec_o.alu_op = ALUOP_XOR;
            OP_SLTIU:  dec_o.alu_op = ALUOP_SLTU;
            OP_BEQ:    begin dec_o.alu_op = ALUOP_SUB;    dec_o.is_branch = 1'b1; end
            OP_BNE:    begin dec_o.alu_op = ALUOP_BNE;    dec_o.is_branch = 1'b1; end
            OP_BGTZ:   begin dec_o.alu_op = ALUOP_BGTZ;   dec_o.is_branch = 1'b1; end
            OP_BLEZ:   begin dec_o.alu_op = ALUOP_BLEZ;   dec_o.is_branch = 1'b1; end
            OP_REGIMM: begin dec_o.alu_op = ALUOP_REGIMM; dec_o.is_branch = 1'b1; end
            OP_J:      dec_o.is_jump = 1'b1;
            OP_JAL:    begin dec_o.is_jump = 1'b1; dec_o.is_link = 1'b1; end
            OP_LUI:    dec_o.alu_op = ALUOP_ADD;
            default:   dec_o.legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multi-cycle MIPS main control; sequences FETCH..WB and drives datapath strobes.
module mips_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       pc_is_zero,
    input  logic       mem_waitrequest,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [3:0] alu_op,
    output logic [2:0] state,
    output logic       active,
    output logic       illegal_instr
);
    logic [2:0] state_q, state_d;
    dec_t       dec;

    mips_opcode_decode u_dec (.opcode_i(opcode), .dec_o(dec));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (pc_is_zero) state_d = S_HALT;
                else begin
                    mem_read = 1'b1;
                    ir_write = !mem_waitrequest;
                    pc_write = !mem_waitrequest;
                    state_d  = mem_waitrequest ? S_FETCH : S_DECODE;
                end
            end
            S_DECODE: begin
                illegal_instr = !dec.legal;
                state_d       = dec.legal ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                alu_op        = dec.alu_op;
                pc_write_cond = dec.is_branch;
                pc_write      = dec.is_jump;
                // jal still needs WB to write the link register
                state_d = (dec.is_load || dec.is_store) ? S_MEM :
                          (dec.is_branch || (dec.is_jump && !dec.is_link)) ? S_FETCH : S_WB;
            end
            S_MEM: begin
                mem_read  = dec.is_load;
                mem_write = dec.is_store;
                if (!mem_waitrequest) state_d = dec.is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = dec.is_load;
                state_d    = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    assign state  = state_q;
    assign active = state_q != S_HALT;
endmodule
